// File: rtl/error_frontend.sv
// Averages windows of 2^LOG2_AVG signed samples and subtracts the average from a latched setpoint, with deadband and symmetric clip.
// Latency: error_valid rises one edge after the edge that captures the Nth sample; no backpressure, a sample is accepted on every meas_valid cycle.
module error_frontend #(
    parameter int WIDTH    = 16,
    parameter int LOG2_AVG = 2,
    parameter int DEADBAND = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic [WIDTH-1:0] setpoint,
    input  logic [WIDTH-1:0] meas,
    input  logic             meas_valid,
    output logic [WIDTH-1:0] error,
    output logic             error_valid,
    output logic             sat_flag,
    output logic             busy
);

    localparam int ACC_W = WIDTH + LOG2_AVG;
    localparam int CNT_W = LOG2_AVG + 1;
    localparam int N     = 1 << LOG2_AVG;

    localparam logic signed [WIDTH:0] DIFF_MAX = (WIDTH+1)'((1 << (WIDTH-1)) - 1);
    localparam logic signed [WIDTH:0] DIFF_MIN = -DIFF_MAX;
    localparam logic [WIDTH:0]        DB_MAG   = (WIDTH+1)'(DEADBAND);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_EMIT  = 2'd2
    } state_t;

    state_t r_state;
    state_t w_next_state;

    logic signed [ACC_W-1:0] r_acc;
    logic [CNT_W-1:0]        r_count;
    logic [WIDTH-1:0]        r_sp;
    logic [WIDTH-1:0]        r_error;
    logic                    r_error_valid;
    logic                    r_sat;

    logic signed [ACC_W-1:0] w_meas_ext;
    logic                    w_last_sample;
    logic                    w_busy;
    logic                    w_fire;
    logic signed [WIDTH-1:0] w_avg;
    logic signed [WIDTH:0]   w_diff;
    logic [WIDTH:0]          w_mag;
    logic [WIDTH-1:0]        w_err_nxt;
    logic                    w_sat_nxt;

    assign w_meas_ext    = ACC_W'($signed(meas));
    assign w_last_sample = meas_valid && (r_count == CNT_W'(N - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (enable) begin
                    w_next_state = S_ACCUM;
                end
            end
            S_ACCUM: begin
                if (!enable) begin
                    w_next_state = S_IDLE;
                end else if (w_last_sample) begin
                    w_next_state = S_EMIT;
                end
            end
            S_EMIT: begin
                // A sample arriving in EMIT opens the next window; with N=1 it also closes it.
                if (!enable) begin
                    w_next_state = S_IDLE;
                end else if (meas_valid && (N == 1)) begin
                    w_next_state = S_EMIT;
                end else begin
                    w_next_state = S_ACCUM;
                end
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    always_comb begin
        w_busy = (r_state != S_IDLE);
        w_fire = (r_state == S_EMIT) && enable;
    end

    // Upper WIDTH bits of the accumulator are the floor of acc / N.
    assign w_avg  = r_acc[ACC_W-1:LOG2_AVG];
    assign w_diff = $signed({r_sp[WIDTH-1], r_sp}) - $signed({w_avg[WIDTH-1], w_avg});
    assign w_mag  = w_diff[WIDTH] ? unsigned'(-w_diff) : unsigned'(w_diff);

    always_comb begin
        w_err_nxt = '0;
        w_sat_nxt = 1'b0;
        if (w_mag <= DB_MAG) begin
            w_err_nxt = '0;
        end else if (w_diff > DIFF_MAX) begin
            w_err_nxt = DIFF_MAX[WIDTH-1:0];
            w_sat_nxt = 1'b1;
        end else if (w_diff < DIFF_MIN) begin
            w_err_nxt = DIFF_MIN[WIDTH-1:0];
            w_sat_nxt = 1'b1;
        end else begin
            w_err_nxt = w_diff[WIDTH-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc         <= '0;
            r_count       <= '0;
            r_sp          <= '0;
            r_error       <= '0;
            r_error_valid <= 1'b0;
            r_sat         <= 1'b0;
        end else begin
            r_error_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (enable) begin
                        r_acc   <= '0;
                        r_count <= '0;
                        r_sp    <= setpoint;
                    end
                end
                S_ACCUM: begin
                    if (enable && meas_valid) begin
                        r_acc   <= r_acc + w_meas_ext;
                        r_count <= r_count + CNT_W'(1);
                    end
                end
                S_EMIT: begin
                    if (w_fire) begin
                        r_error       <= w_err_nxt;
                        r_sat         <= w_sat_nxt;
                        r_error_valid <= 1'b1;
                        r_sp          <= setpoint;
                        r_acc         <= meas_valid ? w_meas_ext : '0;
                        r_count       <= meas_valid ? CNT_W'(1) : '0;
                    end
                end
                default: begin
                    r_acc   <= '0;
                    r_count <= '0;
                end
            endcase
        end
    end

    assign error       = r_error;
    assign error_valid = r_error_valid;
    assign sat_flag    = r_sat;
    assign busy        = w_busy;

endmodule
